// File: rtl/scan_pkg.sv
// Shared definitions for the scan-chain driver and capture blocks.
//   cap_state_t   - capture FSM states
//   drv_state_t   - scan driver FSM encodings, kept here so both ends agree
//   DEF_CHAIN_LEN - default chain length
package scan_pkg;

    localparam int DEF_CHAIN_LEN = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_RST = 3'd1,
        ST_WAIT_REL = 3'd2,
        ST_SHIFT    = 3'd3,
        ST_DONE     = 3'd4
    } cap_state_t;

    typedef enum logic [1:0] {
        DRV_IDLE  = 2'd0,
        DRV_RESET = 2'd1,
        DRV_SHIFT = 2'd2,
        DRV_DONE  = 2'd3
    } drv_state_t;

endpackage

// File: rtl/sync_edge.sv
// N-flop synchroniser with a rising-edge strobe.
//   clk, rst_n - system clock, async active-low reset
//   d          - asynchronous input
//   q          - synchronised level
//   rise       - one-cycle strobe when q goes 0 -> 1
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              q_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            q_prev <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            q_prev <= sync_q[STAGES-1];
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = sync_q[STAGES-1] & ~q_prev;

endmodule

// File: rtl/scan_chain_capture.sv
// Receive stage for the test scan chain: deserialises dout on synchronised
// scan_clk rising edges, then compares against a golden pattern.
//   arm/expected        - start a capture (accepted only when idle)
//   scan_clk/scan_rst/dout - asynchronous chain signals from the driver
//   busy/done           - run in progress / one-cycle result strobe
//   captured/pass/mismatch_cnt/timeout - results, held until next arm
//
// state       | meaning
// ST_IDLE     | waiting for arm
// ST_WAIT_RST | waiting for chain reset assertion
// ST_WAIT_REL | waiting for chain reset release
// ST_SHIFT    | capturing one bit per scan_clk rise, timeout running
// ST_DONE     | one cycle: register results, pulse done
module scan_chain_capture
    import scan_pkg::*;
#(
    parameter int CHAIN_LEN   = DEF_CHAIN_LEN,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           arm,
    input  logic [CHAIN_LEN-1:0]           expected,
    input  logic                           scan_clk,
    input  logic                           scan_rst,
    input  logic                           dout,
    output logic                           busy,
    output logic                           done,
    output logic [CHAIN_LEN-1:0]           captured,
    output logic                           pass,
    output logic [$clog2(CHAIN_LEN+1)-1:0] mismatch_cnt,
    output logic                           timeout
);

    localparam int CW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam int MW = $clog2(CHAIN_LEN + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(CHAIN_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    cap_state_t             state, state_nx;
    logic [CHAIN_LEN-1:0]   expected_q;
    logic [CW-1:0]          bit_cnt;
    logic [TW-1:0]          tmo_cnt;
    logic                   tmo_flag;
    logic [MW-1:0]          mism_nx;

    logic sc_q_unused, sc_rise;
    logic rst_s, rst_rise_unused;
    logic dout_s, dout_rise_unused;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d(scan_clk), .q(sc_q_unused), .rise(sc_rise)
    );
    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_srst (
        .clk(clk), .rst_n(rst_n), .d(scan_rst), .q(rst_s), .rise(rst_rise_unused)
    );
    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_dout (
        .clk(clk), .rst_n(rst_n), .d(dout), .q(dout_s), .rise(dout_rise_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:     if (arm) state_nx = ST_WAIT_RST;
            ST_WAIT_RST: if (rst_s) state_nx = ST_WAIT_REL;
            ST_WAIT_REL: if (!rst_s) state_nx = ST_SHIFT;
            ST_SHIFT: begin
                // A chain reset restarts the run and outranks everything else.
                if (rst_s)                                  state_nx = ST_WAIT_REL;
                else if (sc_rise && bit_cnt == LAST_BIT)    state_nx = ST_DONE;
                else if (!sc_rise && tmo_cnt == TMO_LAST)   state_nx = ST_DONE;
            end
            ST_DONE:     state_nx = ST_IDLE;
            default:     state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        mism_nx = '0;
        for (int i = 0; i < CHAIN_LEN; i++)
            mism_nx = mism_nx + MW'(captured[i] ^ expected_q[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expected_q   <= '0;
            captured     <= '0;
            bit_cnt      <= '0;
            tmo_cnt      <= '0;
            tmo_flag     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            mismatch_cnt <= '0;
            timeout      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arm) begin
                        expected_q   <= expected;
                        captured     <= '0;
                        bit_cnt      <= '0;
                        tmo_flag     <= 1'b0;
                        busy         <= 1'b1;
                        pass         <= 1'b0;
                        mismatch_cnt <= '0;
                        timeout      <= 1'b0;
                    end
                end
                ST_WAIT_REL: tmo_cnt <= '0;
                ST_SHIFT: begin
                    if (rst_s) begin
                        captured <= '0;
                        bit_cnt  <= '0;
                        tmo_cnt  <= '0;
                    end else if (sc_rise) begin
                        captured[bit_cnt] <= dout_s;
                        if (bit_cnt != LAST_BIT) bit_cnt <= bit_cnt + CW'(1);
                        tmo_cnt <= '0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        tmo_flag <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                ST_DONE: begin
                    pass         <= !tmo_flag && (captured == expected_q);
                    mismatch_cnt <= mism_nx;
                    timeout      <= tmo_flag;
                    done         <= 1'b1;
                    busy         <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_scan_chain_capture.sv
module tb_scan_chain_capture;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       arm = 1'b0;
    logic [7:0] expected = 8'h00;
    logic       scan_clk = 1'b0;
    logic       scan_rst = 1'b0;
    logic       dout = 1'b0;

    logic       busy, done, pass, timeout;
    logic [7:0] captured;
    logic [3:0] mismatch_cnt;

    logic       t_busy, t_done, t_pass, t_timeout;
    logic [7:0] t_captured;
    logic [3:0] t_mismatch_cnt;

    scan_chain_capture #(.CHAIN_LEN(8), .SYNC_STAGES(2), .TIMEOUT(1024)) u_dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .expected(expected),
        .scan_clk(scan_clk), .scan_rst(scan_rst), .dout(dout),
        .busy(busy), .done(done), .captured(captured), .pass(pass),
        .mismatch_cnt(mismatch_cnt), .timeout(timeout)
    );

    scan_chain_capture #(.CHAIN_LEN(8), .SYNC_STAGES(2), .TIMEOUT(64)) u_dut_t (
        .clk(clk), .rst_n(rst_n), .arm(arm), .expected(expected),
        .scan_clk(scan_clk), .scan_rst(scan_rst), .dout(dout),
        .busy(t_busy), .done(t_done), .captured(t_captured), .pass(t_pass),
        .mismatch_cnt(t_mismatch_cnt), .timeout(t_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_n = 0;
    int t_done_n = 0;
    int last_done_cyc = 0;
    int rise_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_n++;
            last_done_cyc = cyc;
        end
        if (t_done === 1'b1) t_done_n++;
    end

    typedef struct {
        logic [7:0] exp_pat;
        logic [7:0] dout_pat;
        logic [7:0] cap;
        logic       ok;
        logic [3:0] mism;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_arm(input logic [7:0] e);
        arm = 1'b1;
        expected = e;
        tick(1);
        arm = 1'b0;
    endtask

    task automatic pulse_rst();
        scan_rst = 1'b1;
        tick(8);
        scan_rst = 1'b0;
        tick(8);
    endtask

    task automatic run_bits(input logic [7:0] pat, input int first, input int n, input int half);
        logic [7:0] p;
        p = pat;
        for (int k = 0; k < n; k++) begin
            dout = p[first + k];
            tick(half);
            scan_clk = 1'b1;
            rise_cyc = cyc;
            tick(half);
            scan_clk = 1'b0;
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, t0;

        vecs[0] = '{8'h1C, 8'h1C, 8'h1C, 1'b1, 4'd0};
        vecs[1] = '{8'h1C, 8'hFF, 8'hFF, 1'b0, 4'd5};
        vecs[2] = '{8'hA5, 8'h5A, 8'h5A, 1'b0, 4'd8};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b1, 4'd0};
        vecs[4] = '{8'hF0, 8'hF1, 8'hF1, 1'b0, 4'd1};

        tick(3);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_captured", captured, 0);
        check("rst_pass", pass, 0);
        check("rst_mismatch", mismatch_cnt, 0);
        check("rst_timeout", timeout, 0);
        rst_n = 1'b1;
        tick(3);

        for (int i = 0; i < 5; i++) begin
            b0 = done_n;
            do_arm(vecs[i].exp_pat);
            tick(1);
            check("arm_busy", busy, 1);
            check("arm_clr_captured", captured, 0);
            check("arm_clr_pass", pass, 0);
            pulse_rst();
            run_bits(vecs[i].dout_pat, 0, 8, 64);
            check("vec_done_count", done_n, b0 + 1);
            check("vec_done_latency", last_done_cyc - rise_cyc, 4);
            check("vec_captured", captured, vecs[i].cap);
            check("vec_pass", pass, vecs[i].ok);
            check("vec_mismatch", mismatch_cnt, vecs[i].mism);
            check("vec_timeout", timeout, 0);
            check("vec_busy_low", busy, 0);
        end

        // arm while busy must not disturb the latched pattern
        b0 = done_n;
        do_arm(8'h1C);
        pulse_rst();
        run_bits(8'h1C, 0, 3, 64);
        do_arm(8'h00);
        run_bits(8'h1C, 3, 5, 64);
        check("busyarm_done_count", done_n, b0 + 1);
        check("busyarm_captured", captured, 8'h1C);
        check("busyarm_pass", pass, 1);
        check("busyarm_mismatch", mismatch_cnt, 0);

        // chain reset mid-shift restarts the run
        b0 = done_n;
        do_arm(8'hA5);
        pulse_rst();
        run_bits(8'hFF, 0, 4, 64);
        check("midrst_partial", captured, 8'h0F);
        pulse_rst();
        check("midrst_cleared", captured, 0);
        check("midrst_busy", busy, 1);
        check("midrst_no_done", done_n, b0);
        run_bits(8'hA5, 0, 8, 64);
        check("midrst_done_count", done_n, b0 + 1);
        check("midrst_captured", captured, 8'hA5);
        check("midrst_pass", pass, 1);

        // timeout after 3 edges (fast scan_clk so the short-timeout instance sees them)
        b0 = done_n;
        t0 = t_done_n;
        do_arm(8'h05);
        check("tmo_t_busy", t_busy, 1);
        pulse_rst();
        run_bits(8'h05, 0, 3, 16);
        for (int w = 0; w < 300 && t_done_n == t0; w++) tick(1);
        check("tmo_t_done_count", t_done_n, t0 + 1);
        check("tmo_t_timeout", t_timeout, 1);
        check("tmo_t_pass", t_pass, 0);
        check("tmo_t_captured", t_captured, 8'h05);
        check("tmo_t_mismatch", t_mismatch_cnt, 0);
        check("tmo_main_still_busy", busy, 1);
        check("tmo_main_no_done", done_n, b0);
        for (int w = 0; w < 1300 && done_n == b0; w++) tick(1);
        check("tmo_main_done_count", done_n, b0 + 1);
        check("tmo_main_timeout", timeout, 1);
        check("tmo_main_pass", pass, 0);
        check("tmo_main_captured", captured, 8'h05);

        // async reset mid-shift
        b0 = done_n;
        do_arm(8'h1C);
        tick(1);
        check("ares_arm_clr_timeout", timeout, 0);
        pulse_rst();
        run_bits(8'h1C, 0, 3, 64);
        check("ares_partial", captured, 8'h04);
        check("ares_busy_before", busy, 1);
        tick(20);
        rst_n = 1'b0;
        #1;
        check("ares_busy", busy, 0);
        check("ares_captured", captured, 0);
        check("ares_done", done, 0);
        check("ares_pass", pass, 0);
        check("ares_mismatch", mismatch_cnt, 0);
        check("ares_timeout", timeout, 0);
        tick(5);
        rst_n = 1'b1;
        run_bits(8'h1C, 3, 5, 64);
        check("ares_no_done", done_n, b0);
        do_arm(8'h1C);
        pulse_rst();
        run_bits(8'h1C, 0, 8, 64);
        check("ares_after_done_count", done_n, b0 + 1);
        check("ares_after_captured", captured, 8'h1C);
        check("ares_after_pass", pass, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
